// File: rtl/reset_sequencer_pkg.sv
// Shared types and default parameters for the peripheral reset sequencer.
// Also holds a small helper used to size the shared hold/gap counter.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } rs_state_t;

   localparam int RS_DOMAINS     = 4;
   localparam int RS_HOLD_CYCLES = 16;
   localparam int RS_GAP_CYCLES  = 4;

   function automatic int rs_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between a reset requester and the reset sequencer.
// The requester owns req; the sequencer owns the per-domain resets and status.
interface reset_sequencer_if #(
   parameter int DOMAINS = reset_sequencer_pkg::RS_DOMAINS
);
   logic               req;
   logic [DOMAINS-1:0] domain_rst;
   logic               busy;
   logic               done;

   modport master (
      output req,
      input  domain_rst,
      input  busy,
      input  done
   );

   modport slave (
      input  req,
      output domain_rst,
      output busy,
      output done
   );
endinterface

// File: rtl/reset_sequencer.sv
// Issues active-high resets to DOMAINS peripheral domains: hold all, then
// release one at a time in index order, then pulse done.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | all domains released, waiting for req
//   HOLD    | every domain held in reset for HOLD_CYCLES edges
//   RELEASE | releasing domains 1..DOMAINS-1, one per GAP_CYCLES edges
//   DONE    | single cycle with done high; restarts if a request queued
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int DOMAINS     = RS_DOMAINS,
   parameter int HOLD_CYCLES = RS_HOLD_CYCLES,
   parameter int GAP_CYCLES  = RS_GAP_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   reset_sequencer_if.slave rs
);

   localparam int CW = $clog2(rs_max(HOLD_CYCLES, GAP_CYCLES) + 1);
   localparam int IW = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DOMAINS - 1);

   rs_state_t          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               pending_q, pending_d;
   logic [DOMAINS-1:0] rst_q, rst_d;
   logic               busy_q;
   logic               done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HOLD;
         cnt_q     <= '0;
         idx_q     <= '0;
         pending_q <= 1'b0;
         rst_q     <= '1;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         rst_q     <= rst_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == DONE);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      rst_d     = rst_q;

      // One request may be queued behind a running sequence.
      if (rs.req && (state_q != IDLE)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rs.req) begin
               state_d = HOLD;
               cnt_d   = '0;
               rst_d   = '1;
            end
         end

         HOLD: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == HOLD_LAST) begin
               cnt_d    = '0;
               idx_d    = '0;
               rst_d[0] = 1'b0;
               state_d  = (DOMAINS == 1) ? DONE : RELEASE;
            end
         end

         RELEASE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == GAP_LAST) begin
               cnt_d        = '0;
               idx_d        = idx_q + IW'(1);
               rst_d[idx_d] = 1'b0;
               if (idx_d == LAST_IDX) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            // A request arriving in this very cycle restarts too, so it is not lost in IDLE.
            if (pending_q || rs.req) begin
               state_d   = HOLD;
               cnt_d     = '0;
               rst_d     = '1;
               pending_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rs.domain_rst = rst_q;
   assign rs.busy       = busy_q;
   assign rs.done       = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a timeline table for power-on, software and
// queued requests, plus hand sequences for async reset, held req and a 1/1/1 build.
module tb_reset_sequencer;

   logic clk;
   logic rst_n;

   reset_sequencer_if #(.DOMAINS(4)) rs_if ();
   reset_sequencer_if #(.DOMAINS(1)) if1 ();

   reset_sequencer #(
      .DOMAINS    (4),
      .HOLD_CYCLES(16),
      .GAP_CYCLES (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .rs   (rs_if.slave)
   );

   reset_sequencer #(
      .DOMAINS    (1),
      .HOLD_CYCLES(1),
      .GAP_CYCLES (1)
   ) dut1 (
      .clk  (clk),
      .rst_n(rst_n),
      .rs   (if1.slave)
   );

   typedef struct {
      int         n;
      logic       req_after;
      logic [3:0] rst;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   ncyc   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ncyc++;
   endtask

   task automatic wait_until(input int n, input string name);
      if (n < ncyc) begin
         errors++;
         $display("FAIL %s: target cycle %0d already passed, now %0d", name, n, ncyc);
      end
      while (ncyc < n) tick();
   endtask

   task automatic expect_main(input string name, input logic [3:0] r, input logic b, input logic d);
      check({name, " domain_rst"}, 32'(rs_if.domain_rst), 32'(r));
      check({name, " busy"},       32'(rs_if.busy),       32'(b));
      check({name, " done"},       32'(rs_if.done),       32'(d));
   endtask

   task automatic expect_one(input string name, input logic r, input logic b, input logic d);
      check({name, " domain_rst"}, 32'(if1.domain_rst), 32'(r));
      check({name, " busy"},       32'(if1.busy),       32'(b));
      check({name, " done"},       32'(if1.done),       32'(d));
   endtask

   task automatic add_vec(input int n, input logic rq, input logic [3:0] r, input logic b, input logic d);
      vec_t v;
      v.n = n; v.req_after = rq; v.rst = r; v.busy = b; v.done = d;
      tbl.push_back(v);
   endtask

   initial begin
      int   base;
      int   e0;
      int   k;
      logic [3:0] exp_rst;

      rst_n     = 1'b0;
      rs_if.req = 1'b0;
      if1.req   = 1'b0;

      // Power-on (0..32), software request at 33 (E0=33), queued request (E0=63, second run from 92).
      add_vec(0,   0, 4'b1111, 1, 0);
      add_vec(1,   0, 4'b1111, 1, 0);
      add_vec(15,  0, 4'b1111, 1, 0);
      add_vec(16,  0, 4'b1110, 1, 0);
      add_vec(19,  0, 4'b1110, 1, 0);
      add_vec(20,  0, 4'b1100, 1, 0);
      add_vec(24,  0, 4'b1000, 1, 0);
      add_vec(27,  0, 4'b1000, 1, 0);
      add_vec(28,  0, 4'b0000, 1, 1);
      add_vec(29,  0, 4'b0000, 0, 0);
      add_vec(32,  1, 4'b0000, 0, 0);
      add_vec(33,  0, 4'b1111, 1, 0);
      add_vec(48,  0, 4'b1111, 1, 0);
      add_vec(49,  0, 4'b1110, 1, 0);
      add_vec(53,  0, 4'b1100, 1, 0);
      add_vec(57,  0, 4'b1000, 1, 0);
      add_vec(60,  0, 4'b1000, 1, 0);
      add_vec(61,  0, 4'b0000, 1, 1);
      add_vec(62,  1, 4'b0000, 0, 0);
      add_vec(63,  0, 4'b1111, 1, 0);
      add_vec(72,  1, 4'b1111, 1, 0);
      add_vec(73,  0, 4'b1111, 1, 0);
      add_vec(79,  0, 4'b1110, 1, 0);
      add_vec(91,  0, 4'b0000, 1, 1);
      add_vec(92,  0, 4'b1111, 1, 0);
      add_vec(107, 0, 4'b1111, 1, 0);
      add_vec(108, 0, 4'b1110, 1, 0);
      add_vec(120, 0, 4'b0000, 1, 1);
      add_vec(121, 0, 4'b0000, 0, 0);

      #12;
      expect_main("reset", 4'b1111, 1'b1, 1'b0);
      expect_one("reset d1", 1'b1, 1'b1, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      base  = ncyc;

      foreach (tbl[i]) begin
         wait_until(base + tbl[i].n, "table");
         expect_main($sformatf("table n=%0d", tbl[i].n), tbl[i].rst, tbl[i].busy, tbl[i].done);
         rs_if.req = tbl[i].req_after;
      end

      // Mid-sequence async reset at E0+22, then power-on timing again.
      rs_if.req = 1'b1;
      e0 = ncyc + 1;
      tick();
      rs_if.req = 1'b0;
      wait_until(e0 + 22, "midrst");
      expect_main("midrst before", 4'b1100, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      expect_main("midrst async", 4'b1111, 1'b1, 1'b0);
      expect_one("midrst async d1", 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      expect_main("midrst held", 4'b1111, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      base  = ncyc;
      expect_one("repower d1 E0", 1'b1, 1'b1, 1'b0);
      wait_until(base + 1, "repower");
      expect_one("repower d1 E1", 1'b0, 1'b1, 1'b1);
      expect_main("repower E1", 4'b1111, 1'b1, 1'b0);
      wait_until(base + 2, "repower");
      expect_one("repower d1 E2", 1'b0, 1'b0, 1'b0);
      wait_until(base + 15, "repower");
      expect_main("repower E15", 4'b1111, 1'b1, 1'b0);
      wait_until(base + 16, "repower");
      expect_main("repower E16", 4'b1110, 1'b1, 1'b0);
      wait_until(base + 20, "repower");
      expect_main("repower E20", 4'b1100, 1'b1, 1'b0);
      wait_until(base + 24, "repower");
      expect_main("repower E24", 4'b1000, 1'b1, 1'b0);
      wait_until(base + 28, "repower");
      expect_main("repower E28", 4'b0000, 1'b1, 1'b1);
      wait_until(base + 29, "repower");
      expect_main("repower E29", 4'b0000, 1'b0, 1'b0);

      // Held request: back-to-back 29-cycle sequences; a fourth runs from the request queued during the third.
      rs_if.req = 1'b1;
      for (int j = 0; j < 116; j++) begin
         tick();
         k = j % 29;
         for (int b = 0; b < 4; b++) exp_rst[b] = (k < 16 + 4 * b);
         expect_main($sformatf("held j=%0d", j), exp_rst, 1'b1, (k == 28));
         if (j == 86) rs_if.req = 1'b0;
      end
      tick();
      expect_main("held idle", 4'b0000, 1'b0, 1'b0);

      // One-domain build with unit hold and gap.
      if1.req = 1'b1;
      tick();
      if1.req = 1'b0;
      expect_one("corner E0", 1'b1, 1'b1, 1'b0);
      tick();
      expect_one("corner E1", 1'b0, 1'b1, 1'b1);
      tick();
      expect_one("corner E2", 1'b0, 1'b0, 1'b0);
      tick();
      expect_one("corner E3", 1'b0, 1'b0, 1'b0);
      expect_main("corner main idle", 4'b0000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
